// File: rtl/ea_pkg.sv
// Shared types for the LC-3 effective-address / immediate sequencer.
package ea_pkg;

  typedef enum logic [3:0] {
    OPC_BR   = 4'h0,
    OPC_ADD  = 4'h1,
    OPC_LD   = 4'h2,
    OPC_ST   = 4'h3,
    OPC_JSR  = 4'h4,
    OPC_AND  = 4'h5,
    OPC_LDR  = 4'h6,
    OPC_STR  = 4'h7,
    OPC_RTI  = 4'h8,
    OPC_NOT  = 4'h9,
    OPC_LDI  = 4'hA,
    OPC_STI  = 4'hB,
    OPC_JMP  = 4'hC,
    OPC_RES  = 4'hD,
    OPC_LEA  = 4'hE,
    OPC_TRAP = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    KindPcRel   = 2'd0,
    KindBaseRel = 2'd1,
    KindImm     = 2'd2,
    KindNone    = 2'd3
  } ea_kind_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExt  = 2'd1,
    StAdd  = 2'd2,
    StHold = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    BselPc    = 2'd0,
    BselBaseR = 2'd1,
    BselZero  = 2'd2
  } base_sel_e;

endpackage

// File: rtl/ea_sext.sv
// Combinational IN_W -> 16-bit sign extender.
module ea_sext #(
  parameter int unsigned IN_W = 5
) (
  input  logic [IN_W-1:0] i_val,
  output logic [15:0]     o_val
);

  assign o_val = {{(16 - IN_W){i_val[IN_W-1]}}, i_val};

endmodule

// File: rtl/ea_gen_ctrl.sv
// LC-3 effective-address / immediate sequencer: IDLE -> EXT -> ADD -> HOLD.
// Optional completed-transfer counter enabled by defining EA_PERF_CNT_EN.
module ea_gen_ctrl
  import ea_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned PERF_W = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [15:0]       ir,
  input  logic [15:0]       pc,
  input  logic [15:0]       base_r,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [15:0]       ea,
  output logic [1:0]        kind,
  output logic              illegal
`ifdef EA_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] perf_cnt
`endif
);

  if (DATA_W != 16 || PERF_W == 0) begin : g_bad_cfg
    $error("ea_gen_ctrl: only DATA_W=16 and PERF_W>0 are supported");
  end

  state_e    r_state;
  logic      r_req_ready, r_rsp_valid, r_illegal, r_ill_dec;
  logic [15:0] r_ir, r_pc, r_base, r_sext, r_ea;
  base_sel_e r_bsel;
  ea_kind_e  r_kind, r_kind_dec;

  logic [15:0] w_sext5, w_sext6, w_sext9, w_sext11, w_sext, w_base;
  base_sel_e   w_bsel;
  ea_kind_e    w_kind;
  logic        w_illegal;

  ea_sext #(.IN_W(5))  u_sext5  (.i_val(r_ir[4:0]),  .o_val(w_sext5));
  ea_sext #(.IN_W(6))  u_sext6  (.i_val(r_ir[5:0]),  .o_val(w_sext6));
  ea_sext #(.IN_W(9))  u_sext9  (.i_val(r_ir[8:0]),  .o_val(w_sext9));
  ea_sext #(.IN_W(11)) u_sext11 (.i_val(r_ir[10:0]), .o_val(w_sext11));

  // Decode of the captured IR; consumed only in EXT.
  always_comb begin
    w_sext    = '0;
    w_bsel    = BselZero;
    w_kind    = KindNone;
    w_illegal = 1'b0;
    unique case (opcode_e'(r_ir[15:12]))
      OPC_BR, OPC_LD, OPC_LDI, OPC_LEA, OPC_ST, OPC_STI: begin
        w_sext = w_sext9;
        w_bsel = BselPc;
        w_kind = KindPcRel;
      end
      OPC_JSR: begin
        if (r_ir[11]) begin
          w_sext = w_sext11;
          w_bsel = BselPc;
          w_kind = KindPcRel;
        end else begin
          w_bsel = BselBaseR;
          w_kind = KindBaseRel;
        end
      end
      OPC_JMP: begin
        w_bsel = BselBaseR;
        w_kind = KindBaseRel;
      end
      OPC_LDR, OPC_STR: begin
        w_sext = w_sext6;
        w_bsel = BselBaseR;
        w_kind = KindBaseRel;
      end
      OPC_ADD, OPC_AND: begin
        if (r_ir[5]) begin
          w_sext = w_sext5;
          w_kind = KindImm;
        end
      end
      OPC_RTI, OPC_RES: w_illegal = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    w_base = '0;
    case (r_bsel)
      BselPc:    w_base = r_pc;
      BselBaseR: w_base = r_base;
      default:   w_base = '0;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state     <= StIdle;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_ir        <= '0;
      r_pc        <= '0;
      r_base      <= '0;
      r_sext      <= '0;
      r_bsel      <= BselZero;
      r_kind_dec  <= KindPcRel;
      r_ill_dec   <= 1'b0;
      r_ea        <= '0;
      r_kind      <= KindPcRel;
      r_illegal   <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (r_req_ready && req_valid) begin
            r_ir        <= ir;
            r_pc        <= pc;
            r_base      <= base_r;
            r_req_ready <= 1'b0;
            r_state     <= StExt;
          end else begin
            r_req_ready <= 1'b1;
          end
        end
        StExt: begin
          r_sext     <= w_sext;
          r_bsel     <= w_bsel;
          r_kind_dec <= w_kind;
          r_ill_dec  <= w_illegal;
          r_state    <= StAdd;
        end
        StAdd: begin
          r_ea        <= w_base + r_sext;
          r_kind      <= r_kind_dec;
          r_illegal   <= r_ill_dec;
          r_rsp_valid <= 1'b1;
          r_state     <= StHold;
        end
        StHold: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign ea        = r_ea;
  assign kind      = r_kind;
  assign illegal   = r_illegal;

`ifdef EA_PERF_CNT_EN
  logic [PERF_W-1:0] r_perf;
  logic              w_xfer;

  assign w_xfer = (r_state == StHold) && rsp_ready;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_perf <= '0;
    end else if (w_xfer && (r_perf != {PERF_W{1'b1}})) begin
      r_perf <= r_perf + 1'b1;
    end
  end

  assign perf_cnt = r_perf;
`endif

endmodule

// File: tb/tb_ea_gen_ctrl.sv
// Self-checking bench for ea_gen_ctrl: directed cases, backpressure, reset, random vs model.
module tb_ea_gen_ctrl;

`ifdef EA_PERF_CNT_EN
  localparam int unsigned PW = 2;
`else
  localparam int unsigned PW = 16;
`endif

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        rsp_ready = 1'b0;
  logic [15:0] ir = '0, pc = '0, base_r = '0;
  logic        req_ready, rsp_valid, illegal;
  logic [15:0] ea;
  logic [1:0]  kind;
`ifdef EA_PERF_CNT_EN
  logic [PW-1:0] perf_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int xfers  = 0;

  ea_gen_ctrl #(.DATA_W(16), .PERF_W(PW)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .ir        (ir),
    .pc        (pc),
    .base_r    (base_r),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .ea        (ea),
    .kind      (kind),
    .illegal   (illegal)
`ifdef EA_PERF_CNT_EN
    ,
    .perf_cnt  (perf_cnt)
`endif
  );

  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int sx(input logic [15:0] v, input int w);
    int x;
    x = int'(v) & ((1 << w) - 1);
    if (x >= (1 << (w - 1))) x -= (1 << w);
    return x;
  endfunction

  // Reference: expected response computed from the LC-3 addressing rules.
  task automatic model(input logic [15:0] m_ir, input logic [15:0] m_pc,
                       input logic [15:0] m_base, output logic [15:0] m_ea,
                       output logic [1:0] m_kind, output bit m_ill);
    int op;
    op     = int'(m_ir[15:12]);
    m_ea   = 16'h0;
    m_kind = 2'd3;
    m_ill  = (op == 8) || (op == 13);
    case (op)
      0, 2, 3, 10, 11, 14: begin
        m_ea = 16'(int'(m_pc) + sx(m_ir, 9)); m_kind = 2'd0;
      end
      4: begin
        if (m_ir[11]) begin m_ea = 16'(int'(m_pc) + sx(m_ir, 11)); m_kind = 2'd0; end
        else begin m_ea = m_base; m_kind = 2'd1; end
      end
      12: begin m_ea = m_base; m_kind = 2'd1; end
      6, 7: begin m_ea = 16'(int'(m_base) + sx(m_ir, 6)); m_kind = 2'd1; end
      1, 5: begin
        if (m_ir[5]) begin m_ea = 16'(sx(m_ir, 5)); m_kind = 2'd2; end
      end
      default: ;
    endcase
  endtask

  task automatic check_perf(input string tag);
`ifdef EA_PERF_CNT_EN
    int pmax;
    pmax = (1 << PW) - 1;
    check_eq({tag, "_perf"}, 32'(perf_cnt), 32'((xfers > pmax) ? pmax : xfers));
`else
    if (tag.len() == 0) $display("unused");
`endif
  endtask

  // Issue one request, verify latency, hold behaviour and the transfer.
  task automatic do_req(input string tag, input logic [15:0] t_ir, input logic [15:0] t_pc,
                        input logic [15:0] t_base, input logic [15:0] e_ea,
                        input logic [1:0] e_kind, input bit e_ill, input int hold);
    int n;
    n = 0;
    while (!req_ready && n < 10) begin @(negedge Clk); n++; end
    check_eq({tag, "_ready"}, 32'(req_ready), 32'd1);
    ir = t_ir; pc = t_pc; base_r = t_base; req_valid = 1'b1;
    @(negedge Clk);
    req_valid = 1'b0;
    ir = 16'($urandom); pc = 16'($urandom); base_r = 16'($urandom);
    check_eq({tag, "_busy"}, 32'(req_ready), 32'd0);
    n = 1;
    while (!rsp_valid && n < 8) begin @(negedge Clk); n++; end
    check_eq({tag, "_lat"}, 32'(n), 32'd3);
    for (int i = 0; i < hold; i++) begin
      check_eq({tag, "_hold_vld"}, 32'(rsp_valid), 32'd1);
      check_eq({tag, "_hold_ea"}, 32'(ea), 32'(e_ea));
      check_eq({tag, "_hold_kind"}, 32'(kind), 32'(e_kind));
      check_eq({tag, "_hold_rdy"}, 32'(req_ready), 32'd0);
      @(negedge Clk);
    end
    check_eq({tag, "_ea"}, 32'(ea), 32'(e_ea));
    check_eq({tag, "_kind"}, 32'(kind), 32'(e_kind));
    check_eq({tag, "_ill"}, 32'(illegal), 32'(e_ill));
    rsp_ready = 1'b1;
    @(negedge Clk);
    rsp_ready = 1'b0;
    xfers++;
    check_eq({tag, "_done_vld"}, 32'(rsp_valid), 32'd0);
    check_eq({tag, "_done_rdy"}, 32'(req_ready), 32'd1);
    check_perf(tag);
  endtask

  initial begin
    logic [15:0] r_ir, r_pc, r_base, m_ea;
    logic [1:0]  m_kind;
    bit          m_ill;

    repeat (2) @(negedge Clk);
    check_eq("rst_rdy", 32'(req_ready), 32'd0);
    check_eq("rst_vld", 32'(rsp_valid), 32'd0);
    check_eq("rst_ea", 32'(ea), 32'd0);
    check_eq("rst_kind", 32'(kind), 32'd0);
    check_eq("rst_ill", 32'(illegal), 32'd0);
    check_perf("rst");
    Reset = 1'b0;
    @(negedge Clk);

    do_req("ldr",    16'h607F, 16'h1234, 16'h3000, 16'h2FFF, 2'd1, 1'b0, 0);
    do_req("br",     16'h0FFF, 16'h3001, 16'hAAAA, 16'h3000, 2'd0, 1'b0, 0);
    do_req("jsr_p",  16'h4BFF, 16'h3000, 16'h5555, 16'h33FF, 2'd0, 1'b0, 1);
    do_req("jsr_n",  16'h4C00, 16'h3000, 16'h5555, 16'h2C00, 2'd0, 1'b0, 0);
    do_req("jsrr",   16'h4080, 16'h3000, 16'h4321, 16'h4321, 2'd1, 1'b0, 0);
    do_req("add_i",  16'h1030, 16'h3000, 16'h1111, 16'hFFF0, 2'd2, 1'b0, 0);
    do_req("and_r",  16'h5042, 16'h3000, 16'h1111, 16'h0000, 2'd3, 1'b0, 0);
    do_req("bp",     16'h607F, 16'h0000, 16'h3000, 16'h2FFF, 2'd1, 1'b0, 5);

    // Reset in ADD: outputs clear asynchronously, in-flight request is dropped.
    while (!req_ready) @(negedge Clk);
    ir = 16'h0FFF; pc = 16'h3001; req_valid = 1'b1;
    @(negedge Clk);
    req_valid = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    #1;
    check_eq("rstadd_ea", 32'(ea), 32'd0);
    check_eq("rstadd_kind", 32'(kind), 32'd0);
    check_eq("rstadd_vld", 32'(rsp_valid), 32'd0);
    check_eq("rstadd_rdy", 32'(req_ready), 32'd0);
    xfers = 0;
    check_perf("rstadd");
    @(negedge Clk);
    Reset = 1'b0;
    repeat (3) @(negedge Clk);
    check_eq("rstadd_idle_rdy", 32'(req_ready), 32'd1);
    check_eq("rstadd_idle_vld", 32'(rsp_valid), 32'd0);

    do_req("rti",    16'h8000, 16'h3000, 16'h7777, 16'h0000, 2'd3, 1'b1, 0);
    do_req("res",    16'hD123, 16'h3000, 16'h7777, 16'h0000, 2'd3, 1'b1, 0);

    for (int k = 0; k < 40; k++) begin
      r_ir = 16'($urandom); r_pc = 16'($urandom); r_base = 16'($urandom);
      model(r_ir, r_pc, r_base, m_ea, m_kind, m_ill);
      do_req("rnd", r_ir, r_pc, r_base, m_ea, m_kind, m_ill, int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
